// File: rtl/decode_pkg.sv
// Shared types and constants for the decode stage.
//   regval_t     : one 32-bit architectural register value / instruction word
//   regfile_t    : full register file image (16 entries, 4-bit specifiers)
//   decoded_t    : extracted instruction fields with sign-extended immediate
//   out_t        : complete output-register contents of the decode stage
//   state_t      : decode occupancy state (EMPTY / OUT / FULL)
package decode_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned REG_IDX_W     = 4;
    localparam int unsigned REGFILE_DEPTH = 16;

    typedef logic [XLEN-1:0]      regval_t;
    typedef regval_t [REGFILE_DEPTH-1:0] regfile_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [3:0]           opcode_t;

    // Instruction field bit positions.
    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 28;
    localparam int unsigned RD_MSB     = 27;
    localparam int unsigned RD_LSB     = 24;
    localparam int unsigned RA_MSB     = 23;
    localparam int unsigned RA_LSB     = 20;
    localparam int unsigned RB_MSB     = 19;
    localparam int unsigned RB_LSB     = 16;
    localparam int unsigned IMM_MSB    = 15;
    localparam int unsigned IMM_LSB    = 0;

    localparam opcode_t OPCODE_NOP = 4'h0;

    // The all-zero word is the Nop instruction.
    localparam regval_t NOP = 32'h0000_0000;

    typedef struct packed {
        opcode_t  opcode;
        reg_idx_t rd;
        reg_idx_t ra;
        reg_idx_t rb;
        regval_t  imm;
    } decoded_t;

    typedef struct packed {
        logic     valid;
        decoded_t dec;
        regval_t  a;
        regval_t  b;
        regval_t  pc;
    } out_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_OUT   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // Decode of the Nop word: every field zero.
    localparam decoded_t NOP_DECODED = '{
        opcode: OPCODE_NOP,
        rd:     4'h0,
        ra:     4'h0,
        rb:     4'h0,
        imm:    32'h0000_0000
    };

    // Contents of a non-valid output register.
    localparam out_t OUT_NOP = '{
        valid: 1'b0,
        dec:   NOP_DECODED,
        a:     32'h0000_0000,
        b:     32'h0000_0000,
        pc:    32'h0000_0000
    };

    function automatic regval_t sign_extend_imm(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/decode_fields.sv
// Combinational field extraction for one instruction word.
//   instruction : raw 32-bit instruction word
//   fields      : opcode, rd, ra, rb and sign-extended immediate
module decode_fields
    import decode_pkg::*;
(
    input  regval_t  instruction,
    output decoded_t fields
);

    // Slice the word into its fields; the immediate is sign-extended.
    always_comb begin
        fields        = NOP_DECODED;
        fields.opcode = instruction[OPCODE_MSB:OPCODE_LSB];
        fields.rd     = instruction[RD_MSB:RD_LSB];
        fields.ra     = instruction[RA_MSB:RA_LSB];
        fields.rb     = instruction[RB_MSB:RB_LSB];
        fields.imm    = sign_extend_imm(instruction[IMM_MSB:IMM_LSB]);
    end

endmodule

// File: rtl/decode.sv
// Decode pipeline stage with a one-entry skid buffer.
//   clock, reset_n        : rising-edge clock, asynchronous active-low reset
//   registers             : register file image used for operand reads
//   in_valid/in_instruction/in_pc : instruction from fetch
//   hold_out              : stall to fetch, high exactly while the skid is full
//   hold_in               : stall from downstream, freezes valid outputs
//   flush                 : discard everything in flight
//   out_*                 : registered decoded fields, operands and pc
module decode
    import decode_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16
) (
    input  logic     clock,
    input  logic     reset_n,
    input  regfile_t registers,
    input  logic     in_valid,
    input  regval_t  in_instruction,
    input  regval_t  in_pc,
    output logic     hold_out,
    input  logic     hold_in,
    input  logic     flush,
    output logic     out_valid,
    output opcode_t  out_opcode,
    output reg_idx_t out_rd,
    output reg_idx_t out_ra,
    output reg_idx_t out_rb,
    output regval_t  out_imm,
    output regval_t  out_a,
    output regval_t  out_b,
    output regval_t  out_pc
);

    state_t   state_r;
    out_t     out_r;
    logic     skid_valid_r;
    regval_t  skid_instr_r;
    regval_t  skid_pc_r;
    logic     hold_out_r;

    decoded_t in_dec_s;
    decoded_t skid_dec_s;
    out_t     in_entry_s;
    out_t     skid_entry_s;
    logic     accept_s;

    // Register 0 is hard-wired to zero; specifiers beyond NUM_REGS also read zero.
    function automatic regval_t read_reg(input regfile_t rf, input reg_idx_t idx);
        regval_t val;
        if (idx == 4'h0) begin
            val = 32'h0000_0000;
        end else if (32'(idx) >= NUM_REGS) begin
            val = 32'h0000_0000;
        end else begin
            val = rf[idx];
        end
        return val;
    endfunction

    decode_fields u_fields_in (
        .instruction (in_instruction),
        .fields      (in_dec_s)
    );

    decode_fields u_fields_skid (
        .instruction (skid_instr_r),
        .fields      (skid_dec_s)
    );

    // Fetch only hands over an instruction while we are not stalling it.
    assign accept_s = in_valid & ~hold_out_r;

    // Candidate output-register contents; operands are read in the cycle the
    // entry lands in the output register, so a skid entry sees fresh values.
    always_comb begin
        in_entry_s       = OUT_NOP;
        in_entry_s.valid = 1'b1;
        in_entry_s.dec   = in_dec_s;
        in_entry_s.a     = read_reg(registers, in_dec_s.ra);
        in_entry_s.b     = read_reg(registers, in_dec_s.rb);
        in_entry_s.pc    = in_pc;

        skid_entry_s       = OUT_NOP;
        skid_entry_s.valid = skid_valid_r;
        skid_entry_s.dec   = skid_dec_s;
        skid_entry_s.a     = read_reg(registers, skid_dec_s.ra);
        skid_entry_s.b     = read_reg(registers, skid_dec_s.rb);
        skid_entry_s.pc    = skid_pc_r;
    end

    // Occupancy FSM with output register, skid buffer and registered stall.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_EMPTY;
            out_r        <= OUT_NOP;
            skid_valid_r <= 1'b0;
            skid_instr_r <= NOP;
            skid_pc_r    <= 32'h0000_0000;
            hold_out_r   <= 1'b0;
        end else if (flush) begin
            state_r      <= ST_EMPTY;
            out_r        <= OUT_NOP;
            skid_valid_r <= 1'b0;
            skid_instr_r <= NOP;
            skid_pc_r    <= 32'h0000_0000;
            hold_out_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    // Nothing valid is being held, so an arrival may fill the
                    // output register even while downstream stalls.
                    if (accept_s) begin
                        out_r   <= in_entry_s;
                        state_r <= ST_OUT;
                    end else begin
                        out_r   <= OUT_NOP;
                        state_r <= ST_EMPTY;
                    end
                    hold_out_r <= 1'b0;
                end
                ST_OUT: begin
                    if (!hold_in) begin
                        if (accept_s) begin
                            out_r   <= in_entry_s;
                            state_r <= ST_OUT;
                        end else begin
                            out_r   <= OUT_NOP;
                            state_r <= ST_EMPTY;
                        end
                        hold_out_r <= 1'b0;
                    end else if (accept_s) begin
                        // Output frozen: park the raw word, operands read later.
                        skid_valid_r <= 1'b1;
                        skid_instr_r <= in_instruction;
                        skid_pc_r    <= in_pc;
                        state_r      <= ST_FULL;
                        hold_out_r   <= 1'b1;
                    end else begin
                        state_r    <= ST_OUT;
                        hold_out_r <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (!hold_in) begin
                        out_r        <= skid_entry_s;
                        skid_valid_r <= 1'b0;
                        state_r      <= ST_OUT;
                        hold_out_r   <= 1'b0;
                    end else begin
                        state_r    <= ST_FULL;
                        hold_out_r <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= ST_EMPTY;
                    out_r        <= OUT_NOP;
                    skid_valid_r <= 1'b0;
                    skid_instr_r <= NOP;
                    skid_pc_r    <= 32'h0000_0000;
                    hold_out_r   <= 1'b0;
                end
            endcase
        end
    end

    assign hold_out   = hold_out_r;
    assign out_valid  = out_r.valid;
    assign out_opcode = out_r.dec.opcode;
    assign out_rd     = out_r.dec.rd;
    assign out_ra     = out_r.dec.ra;
    assign out_rb     = out_r.dec.rb;
    assign out_imm    = out_r.dec.imm;
    assign out_a      = out_r.a;
    assign out_b      = out_r.b;
    assign out_pc     = out_r.pc;

endmodule

// File: tb/tb_decode.sv
// Directed self-checking bench for the decode stage.
module tb_decode;
    import decode_pkg::*;

    logic     clock;
    logic     reset_n;
    regfile_t regs;
    logic     in_valid;
    regval_t  in_instruction;
    regval_t  in_pc;
    logic     hold_out;
    logic     hold_in;
    logic     flush;
    logic     out_valid;
    opcode_t  out_opcode;
    reg_idx_t out_rd;
    reg_idx_t out_ra;
    reg_idx_t out_rb;
    regval_t  out_imm;
    regval_t  out_a;
    regval_t  out_b;
    regval_t  out_pc;

    int tests_run;
    int tests_failed;

    logic [39:0] hold_pat;

    decode #(.NUM_REGS(16)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .registers      (regs),
        .in_valid       (in_valid),
        .in_instruction (in_instruction),
        .in_pc          (in_pc),
        .hold_out       (hold_out),
        .hold_in        (hold_in),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_opcode     (out_opcode),
        .out_rd         (out_rd),
        .out_ra         (out_ra),
        .out_rb         (out_rb),
        .out_imm        (out_imm),
        .out_a          (out_a),
        .out_b          (out_b),
        .out_pc         (out_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run = tests_run + 1;
        if (obs !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic regval_t mk_stream(input int i);
        logic [15:0] v;
        v = 16'(i);
        return {4'h6, 4'h1, v[3:0], 4'h2, v};
    endfunction

    initial begin
        int idx;
        int got;
        int cyc;
        logic consume;
        logic acc;
        regval_t exp_a;

        tests_run      = 0;
        tests_failed   = 0;
        hold_pat       = 40'hB3_5A_C6_1D_E9;
        reset_n        = 1'b0;
        regs           = '0;
        in_valid       = 1'b0;
        in_instruction = 32'h0000_0000;
        in_pc          = 32'h0000_0000;
        hold_in        = 1'b0;
        flush          = 1'b0;

        // Reset state
        #12;
        check("rst_valid", 64'(out_valid), 64'h0);
        check("rst_hold", 64'(hold_out), 64'h0);
        check("rst_opcode", 64'(out_opcode), 64'h0);
        check("rst_pc", 64'(out_pc), 64'h0);
        check("rst_a", 64'(out_a), 64'h0);
        reset_n = 1'b1;

        // Basic decode, one-cycle latency
        regs[3]        = 32'h0000_0033;
        regs[4]        = 32'h0000_0044;
        in_valid       = 1'b1;
        in_instruction = 32'h1234_FFFC;
        in_pc          = 32'h0000_0040;
        step();
        check("basic_valid", 64'(out_valid), 64'h1);
        check("basic_opcode", 64'(out_opcode), 64'h1);
        check("basic_rd", 64'(out_rd), 64'h2);
        check("basic_ra", 64'(out_ra), 64'h3);
        check("basic_rb", 64'(out_rb), 64'h4);
        check("basic_imm", 64'(out_imm), 64'hFFFF_FFFC);
        check("basic_pc", 64'(out_pc), 64'h40);
        check("basic_a", 64'(out_a), 64'h33);
        check("basic_b", 64'(out_b), 64'h44);

        // Stall while OUT: next instruction goes to the skid
        regs[5]        = 32'h0000_0007;
        hold_in        = 1'b1;
        in_instruction = 32'h2156_0010;
        in_pc          = 32'h0000_0044;
        step();
        check("skid_hold", 64'(hold_out), 64'h1);
        check("skid_pc_frozen", 64'(out_pc), 64'h40);
        check("skid_valid", 64'(out_valid), 64'h1);
        // Operand changes while held; fetch would present a new word but is stalled
        regs[5]        = 32'h0000_0009;
        in_instruction = 32'h3000_0001;
        in_pc          = 32'h0000_0048;
        step();
        check("skid_hold2", 64'(hold_out), 64'h1);
        check("skid_pc_frozen2", 64'(out_pc), 64'h40);
        hold_in  = 1'b0;
        in_valid = 1'b0;
        step();
        check("rel_pc", 64'(out_pc), 64'h44);
        check("rel_hold", 64'(hold_out), 64'h0);
        check("rel_opcode", 64'(out_opcode), 64'h2);
        check("rel_ra", 64'(out_ra), 64'h5);
        check("rel_a_fresh", 64'(out_a), 64'h9);
        check("rel_imm", 64'(out_imm), 64'h10);

        // Flush while FULL with in_valid
        hold_in        = 1'b1;
        in_valid       = 1'b1;
        in_instruction = 32'h3000_0001;
        in_pc          = 32'h0000_0048;
        step();
        check("full2_hold", 64'(hold_out), 64'h1);
        flush = 1'b1;
        step();
        check("flush_valid", 64'(out_valid), 64'h0);
        check("flush_hold", 64'(hold_out), 64'h0);
        check("flush_opcode", 64'(out_opcode), 64'h0);
        check("flush_imm", 64'(out_imm), 64'h0);
        check("flush_pc", 64'(out_pc), 64'h0);
        check("flush_a", 64'(out_a), 64'h0);
        flush    = 1'b0;
        hold_in  = 1'b0;
        in_valid = 1'b0;
        step();
        check("flush_no_0x48", 64'(out_valid), 64'h0);

        // Flush in OUT together with a new instruction
        in_valid       = 1'b1;
        in_instruction = 32'h7ABC_0005;
        in_pc          = 32'h0000_0050;
        step();
        check("pre_flush_pc", 64'(out_pc), 64'h50);
        flush          = 1'b1;
        in_instruction = 32'h7ABC_0006;
        in_pc          = 32'h0000_0054;
        step();
        check("flush_in_valid", 64'(out_valid), 64'h0);
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        check("flush_in_dropped", 64'(out_valid), 64'h0);

        // Register 0 reads zero; negative and positive immediates
        regs[0]        = 32'hDEAD_BEEF;
        in_valid       = 1'b1;
        in_instruction = 32'h4100_8000;
        in_pc          = 32'h0000_0060;
        step();
        check("r0_a", 64'(out_a), 64'h0);
        check("r0_b", 64'(out_b), 64'h0);
        check("imm_neg", 64'(out_imm), 64'hFFFF_8000);
        in_instruction = 32'h5000_7FFF;
        in_pc          = 32'h0000_0064;
        step();
        check("imm_pos", 64'(out_imm), 64'h0000_7FFF);
        check("imm_pos_opcode", 64'(out_opcode), 64'h5);
        in_valid = 1'b0;
        step();
        check("drain_valid", 64'(out_valid), 64'h0);

        // Stream of 16 with hold_in toggling
        for (int k = 1; k < 16; k++) begin
            regs[k] = 32'h0000_0100 + 32'(k);
        end
        idx = 0;
        got = 0;
        cyc = 0;
        while (got < 16 && cyc < 300) begin
            hold_in        = hold_pat[cyc % 40];
            in_valid       = (idx < 16);
            in_instruction = mk_stream(idx);
            in_pc          = 32'(idx * 4);
            consume        = out_valid & ~hold_in;
            acc            = in_valid & ~hold_out;
            if (consume) begin
                exp_a = (got == 0) ? 32'h0 : (32'h0000_0100 + 32'(got));
                check("stream_pc", 64'(out_pc), 64'(got * 4));
                check("stream_imm", 64'(out_imm), 64'(got));
                check("stream_a", 64'(out_a), 64'(exp_a));
                check("stream_b", 64'(out_b), 64'h102);
                got = got + 1;
            end
            step();
            if (acc) begin
                idx = idx + 1;
            end
            cyc = cyc + 1;
        end
        check("stream_count", 64'(got), 64'd16);
        hold_in  = 1'b0;
        in_valid = 1'b0;
        step();
        step();
        check("stream_no_extra", 64'(out_valid), 64'h0);

        // Asynchronous reset while FULL
        in_valid       = 1'b1;
        in_instruction = 32'h1234_FFFC;
        in_pc          = 32'h0000_0080;
        step();
        hold_in = 1'b1;
        in_pc   = 32'h0000_0084;
        step();
        check("pre_rst_hold", 64'(hold_out), 64'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'h0);
        check("arst_hold", 64'(hold_out), 64'h0);
        check("arst_opcode", 64'(out_opcode), 64'h0);
        check("arst_imm", 64'(out_imm), 64'h0);
        check("arst_pc", 64'(out_pc), 64'h0);
        #1;
        reset_n        = 1'b1;
        hold_in        = 1'b0;
        in_valid       = 1'b1;
        in_instruction = 32'h9000_0000;
        in_pc          = 32'h0000_0090;
        step();
        check("post_rst_valid", 64'(out_valid), 64'h1);
        check("post_rst_pc", 64'(out_pc), 64'h90);
        check("post_rst_opcode", 64'(out_opcode), 64'h9);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, meaning number of architectural registers; register specifiers are 4 bits wide.
REQ-002 SHALL have port clock  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port registers  in  regfile_t  current register file contents, used for operand reads.
REQ-005 SHALL have port in_valid  in  1  fetch output holds a valid instruction.
REQ-006 SHALL have port in_instruction  in  regval_t(32)  fetched instruction word.
REQ-007 SHALL have port in_pc  in  regval_t(32)  address of in_instruction.
REQ-008 SHALL have port hold_out  in-direction out  1  stall request to fetch; fetch freezes its outputs while high.
REQ-009 SHALL have port hold_in  in  1  downstream stall; decode outputs frozen while high.
REQ-010 SHALL have port flush  in  1  downstream PC change; discard all in-flight instructions.
REQ-011 SHALL have ports out_valid(1), out_opcode(4), out_rd(4), out_ra(4), out_rb(4), out_imm(32), out_a(32), out_b(32), out_pc(32), all out, registered decoded fields and operand values.

Function
REQ-012 SHALL decode fields: opcode=[31:28], rd=[27:24], ra=[23:20], rb=[19:16], imm=[15:0] sign-extended to 32 bits.
REQ-013 SHALL read out_a=registers[ra], out_b=registers[rb] in the capture cycle; register 0 reads as 0.
REQ-014 SHALL have latency one cycle: an instruction accepted at edge N appears on outputs after edge N when hold_in is low.
REQ-015 SHALL hold a one-entry skid buffer (instruction, pc, valid).
REQ-016 SHALL operate in states EMPTY (output invalid, skid empty), OUT (output valid, skid empty), FULL (output valid, skid valid).
REQ-017 SHALL treat in_valid as an accepted instruction only when hold_out is low.
REQ-018 In EMPTY or OUT with hold_in low: an accepted instruction SHALL load the output register; no instruction SHALL clear out_valid and load Nop (EMPTY).
REQ-019 In OUT with hold_in high: an accepted instruction SHALL go to the skid; the state SHALL become FULL.
REQ-020 In FULL with hold_in low: the skid SHALL move to the output register and the state SHALL become OUT; an instruction is not accepted that cycle.
REQ-021 In FULL with hold_in high: state SHALL be unchanged.
REQ-022 hold_out SHALL be registered; it SHALL be 1 exactly when the state is FULL.
REQ-023 Operands for a skid entry SHALL be re-read when the entry moves to the output register, not when it is captured.
REQ-024 flush SHALL take priority over hold_in and in_valid: at the next edge, skid cleared, out_valid=0, outputs=Nop decode, state EMPTY, hold_out=0.
REQ-025 With flush and in_valid in the same cycle, the incoming instruction SHALL be discarded.
REQ-026 Fields of a non-valid output SHALL equal the decode of Nop with out_pc=0.

Reset
REQ-027 reset_n low SHALL asynchronously force state EMPTY, out_valid=0, hold_out=0, skid valid=0, decoded outputs=Nop decode, out_a=out_b=out_pc=0.
REQ-028 Reset mid-operation SHALL discard output and skid contents; first acceptance is possible at the first edge after release.

Structure
REQ-029 regval_t, regfile_t, Nop, and the opcode/field bit-position constants SHALL be in the shared package.
REQ-030 A decoded-instruction struct type SHALL be in the shared package.
REQ-031 Field extraction SHALL be one combinational sub-module, decode_fields, instantiated twice (input path, skid path).

Verification
REQ-032 Reset then in_valid with 32'h1234_FFFC at pc 0x40 -> next cycle out_valid=1, opcode 1, rd 2, ra 3, rb 4, imm 0xFFFF_FFFC, pc 0x40.
REQ-033 hold_in=1 while OUT, new instruction at pc 0x44 -> FULL and hold_out=1; output still pc 0x40; hold_in=0 -> output pc 0x44, hold_out=0.
REQ-034 Flush while FULL together with in_valid -> next cycle out_valid=0, hold_out=0, Nop fields; the pc 0x48 instruction is never output.
REQ-035 Skid entry with ra=5; registers[5] changes 7->9 while held -> out_a=9 on release.
REQ-036 Back-to-back stream pc 0x0..0x3C with hold_in toggled randomly -> all 16 instructions output in order, none duplicated or lost.
REQ-037 Assert reset_n low asynchronously while FULL -> outputs immediately invalid with Nop fields, hold_out=0, no clock edge required.
